// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter and sequencer that shares one combinational ALU between two clients.
// One transaction is in flight at a time: IDLE (grant) -> EXEC (ALU evaluates) -> RESP (return result).
module alu_share_arbiter #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  input  logic              rsp0_ready,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake rules: a request transfers on a rising edge where reqN_valid && reqN_ready;
  // a response transfers where rspN_valid && rspN_ready. Valid never depends on ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_q;   // client granted last; resets to 1 so client 0 is favoured first
  logic   owner_q;
  logic   grant0, grant1, take, rsp_done;

  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_q);
    grant1     = req1_valid && (!req0_valid || !last_q);
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    take       = 1'b0;
    rsp_done   = 1'b0;
    state_d    = state_q;
    case (state_q)
      S_IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        take       = grant0 || grant1;
        if (take) state_d = S_EXEC;
      end
      S_EXEC: state_d = S_RESP;
      S_RESP: begin
        rsp0_valid = !owner_q;
        rsp1_valid = owner_q;
        rsp_done   = owner_q ? rsp1_ready : rsp0_ready;
        if (rsp_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      if (take) begin
        last_q  <= grant1;
        owner_q <= grant1;
        alu_op  <= grant1 ? req1_op : req0_op;
        alu_a   <= grant1 ? req1_a  : req0_a;
        alu_b   <= grant1 ? req1_b  : req0_b;
      end
      if (state_q == S_EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: provides a reference ALU, runs a vector table
// of single transactions, then contention, backpressure and reset-in-flight sequences.
module tb_alu_share_arbiter;

  localparam int DATA_W = 16;
  localparam int OP_W   = 3;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic [OP_W-1:0]   req0_op = '0, req1_op = '0;
  logic [DATA_W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic              req0_ready, req1_ready;
  logic              rsp0_valid, rsp1_valid;
  logic              rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              busy;
  logic [1:0]        dbg_state;

  int errors = 0;
  int checks = 0;

  alu_share_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference shared ALU (zero flag is 1 when the result is non-zero)
  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = {{(DATA_W-1){1'b0}}, alu_a == alu_b};
      3'd5: alu_result = {{(DATA_W-1){1'b0}}, alu_a <= alu_b};
      default: alu_result = '0;
    endcase
    alu_zero = |alu_result;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic v, input logic [OP_W-1:0] op,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (c == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " req0_ready"}, 32'(req0_ready), 0);
    chk({tag, " req1_ready"}, 32'(req1_ready), 0);
    chk({tag, " rsp0_valid"}, 32'(rsp0_valid), 0);
    chk({tag, " rsp1_valid"}, 32'(rsp1_valid), 0);
    chk({tag, " rsp_result"}, 32'(rsp_result), 0);
    chk({tag, " rsp_zero"},   32'(rsp_zero), 0);
    chk({tag, " alu_op"},     32'(alu_op), 0);
    chk({tag, " alu_a"},      32'(alu_a), 0);
    chk({tag, " alu_b"},      32'(alu_b), 0);
    chk({tag, " busy"},       32'(busy), 0);
  endtask

  // One complete transaction from a single client with rsp ready held high.
  task automatic do_txn(input int c, input logic [OP_W-1:0] op, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] er, input logic ez);
    set_req(c, 1'b1, op, a, b);
    #1;
    chk("grant ready", 32'(c == 0 ? req0_ready : req1_ready), 1);
    chk("other ready", 32'(c == 0 ? req1_ready : req0_ready), 0);
    tick();
    set_req(c, 1'b0, '0, '0, '0);
    chk("exec state", 32'(dbg_state), 32'(ST_EXEC));
    chk("exec alu_op", 32'(alu_op), 32'(op));
    chk("exec alu_a", 32'(alu_a), 32'(a));
    chk("exec alu_b", 32'(alu_b), 32'(b));
    tick();
    chk("resp own valid", 32'(c == 0 ? rsp0_valid : rsp1_valid), 1);
    chk("resp other valid", 32'(c == 0 ? rsp1_valid : rsp0_valid), 0);
    chk("resp result", 32'(rsp_result), 32'(er));
    chk("resp zero", 32'(rsp_zero), 32'(ez));
    tick();
    chk("back idle busy", 32'(busy), 0);
    chk("back idle rsp0", 32'(rsp0_valid), 0);
    chk("back idle rsp1", 32'(rsp1_valid), 0);
    chk("alu_a held", 32'(alu_a), 32'(a));
  endtask

  typedef struct {
    int                client;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] exp_result;
    logic              exp_zero;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{0, 3'd0, 16'h0003, 16'h0004, 16'h0007, 1'b1};
    vecs[1] = '{1, 3'd1, 16'h0005, 16'h0005, 16'h0000, 1'b0};
    vecs[2] = '{1, 3'd5, 16'hFFFF, 16'h0001, 16'h0000, 1'b0};
    vecs[3] = '{0, 3'd5, 16'h0001, 16'hFFFF, 16'h0001, 1'b1};
    vecs[4] = '{0, 3'd7, 16'h1234, 16'h5678, 16'h0000, 1'b0};
    vecs[5] = '{1, 3'd4, 16'h00AA, 16'h00AA, 16'h0001, 1'b1};

    // Reset state
    #2;
    chk_all_zero("reset");
    chk("reset state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    rst_n = 1'b1;
    tick();

    // Table-driven single-client transactions
    for (int i = 0; i < 6; i++) begin
      do_txn(vecs[i].client, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_result, vecs[i].exp_zero);
    end

    // Contention from a fresh reset: grants alternate 0,1,0,1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    set_req(0, 1'b1, 3'd2, 16'h00F0, 16'h0FF0);
    set_req(1, 1'b1, 3'd3, 16'h0F00, 16'h00FF);
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("cont ready0", 32'(req0_ready), 32'((g % 2) == 0));
      chk("cont ready1", 32'(req1_ready), 32'((g % 2) == 1));
      tick();
      chk("cont exec ready0", 32'(req0_ready), 0);
      chk("cont exec ready1", 32'(req1_ready), 0);
      chk("cont alu_op", 32'(alu_op), (g % 2) == 0 ? 32'd2 : 32'd3);
      tick();
      chk("cont rsp0", 32'(rsp0_valid), 32'((g % 2) == 0));
      chk("cont rsp1", 32'(rsp1_valid), 32'((g % 2) == 1));
      chk("cont result", 32'(rsp_result), (g % 2) == 0 ? 32'h00F0 : 32'h0FFF);
      chk("cont resp ready0", 32'(req0_ready), 0);
      tick();
    end
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    tick();

    // Backpressure on client 0 while client 1 waits; rsp1_ready from non-owner ignored
    rsp0_ready = 1'b0;
    set_req(0, 1'b1, 3'd0, 16'h1234, 16'h0001);
    #1;
    chk("bp grant0", 32'(req0_ready), 1);
    tick();
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b1, 3'd4, 16'h00AA, 16'h00AA);
    chk("bp exec ready1", 32'(req1_ready), 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp state", 32'(dbg_state), 32'(ST_RESP));
      chk("bp rsp0", 32'(rsp0_valid), 1);
      chk("bp rsp1", 32'(rsp1_valid), 0);
      chk("bp result", 32'(rsp_result), 32'h1235);
      chk("bp ready1", 32'(req1_ready), 0);
      tick();
    end
    rsp0_ready = 1'b1;
    #1;
    chk("bp no comb path", 32'(req1_ready), 0);
    tick();
    chk("bp grant1 after", 32'(req1_ready), 1);
    tick();
    set_req(1, 1'b0, '0, '0, '0);
    tick();
    chk("bp rsp1", 32'(rsp1_valid), 1);
    chk("bp rsp1 result", 32'(rsp_result), 32'h0001);
    chk("bp rsp1 zero", 32'(rsp_zero), 1);
    tick();

    // Reset asserted during EXEC abandons the transaction
    set_req(0, 1'b1, 3'd0, 16'h5555, 16'h0001);
    tick();
    set_req(0, 1'b0, '0, '0, '0);
    chk("rst pre exec", 32'(dbg_state), 32'(ST_EXEC));
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst exec");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post rst rsp0", 32'(rsp0_valid), 0);
      chk("post rst rsp1", 32'(rsp1_valid), 0);
      chk("post rst busy", 32'(busy), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
